// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op/flag encodings, FSM states and operand classification
// for the FPU execute stage.
package fpu_pkg;
   localparam int OP_ADD = 0;
   localparam int OP_SUB = 1;
   localparam int OP_MUL = 2;
   localparam int OP_DIV = 3;
   localparam int FLG_INV = 0;
   localparam int FLG_DZ  = 1;
   localparam int FLG_OF  = 2;
   localparam int FLG_UF  = 3;

   typedef enum logic [1:0] {IDLE, EXEC, DIV, HOLD} state_t;
   typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} cls_t;

   // Canonical quiet NaN, right-aligned in 64 bits; callers keep the low W bits.
   function automatic logic [63:0] qnan(input int exp_w, input int man_w);
      return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
   endfunction

   // Denormals classify as zero, so they are flushed everywhere downstream.
   function automatic cls_t classify(input logic e_all1, input logic e_zero, input logic m_zero);
      return e_all1 ? (m_zero ? CLS_INF : CLS_NAN) : e_zero ? CLS_ZERO : CLS_NORM;
   endfunction
endpackage

// File: rtl/fpu_mant_div.sv
// fpu_mant_div: restoring divider for normalised mantissas, one quotient bit
// per cycle, N+1 quotient bits with the integer bit first.
module fpu_mant_div #(
   parameter int N = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] num,
   input  logic [N-1:0] den,
   output logic         done,
   output logic [N:0]   quo
);
   localparam int CW = $clog2(N + 2);
   logic [N:0]    r_rem;
   logic [N-1:0]  r_den;
   logic [N:0]    r_quo;
   logic [CW-1:0] r_cnt;
   logic          r_run;
   logic [N+1:0]  w_diff;
   logic          w_bit;
   assign w_diff = {1'b0, r_rem} - {2'b0, r_den};
   assign w_bit  = ~w_diff[N+1];
   assign done   = r_run && r_cnt == '0;
   assign quo    = r_quo;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rem <= '0;
         r_den <= '0;
         r_quo <= '0;
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (start) begin
         r_rem <= {1'b0, num};
         r_den <= den;
         r_quo <= '0;
         r_cnt <= CW'(N + 1);
         r_run <= 1'b1;
      end else if (r_cnt != '0) begin
         r_rem <= {w_bit ? N'(w_diff) : r_rem[N-1:0], 1'b0};
         r_quo <= {r_quo[N-1:0], w_bit};
         r_cnt <= r_cnt - 1'b1;
      end else begin
         r_run <= 1'b0;
      end
   end
endmodule

// File: rtl/fpu_exe_stage.sv
// fpu_exe_stage: FPU execute stage; add/sub/mul in one cycle, div through an
// iterative mantissa divider, results held until downstream accepts.
module fpu_exe_stage
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               op,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic [3:0]               flags,
   output logic                     busy
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int E    = MAN_W + 4;
   localparam int BIAS = 2 ** (EXP_W - 1) - 1;
   localparam int EMAX = 2 ** EXP_W - 1;
   localparam logic [63:0]  QN64    = qnan(EXP_W, MAN_W);
   localparam logic [W-1:0] QNAN    = QN64[W-1:0];
   localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

   state_t             r_state;
   logic [W-1:0]       r_a, r_b, r_res;
   logic [3:0]         r_op, r_flg;
   logic               r_valid;
   logic               w_accept, w_div_start, w_div_done, w_legal, w_nan;
   logic [MAN_W+1:0]   w_quo;
   logic [EXP_W-1:0]   w_ea, w_eb, w_be, w_se, w_d;
   logic [MAN_W:0]     w_ma, w_mb, w_bm, w_sm;
   logic               w_sa, w_sbe, w_sx, w_swap, w_bs, w_ss, w_stk;
   cls_t               w_ca, w_cb;
   logic [E-1:0]       w_bx, w_sxx, w_sh, w_norm;
   logic [E:0]         w_sum;
   int                 w_lz, w_pe, w_qe;
   logic [2*MAN_W+1:0] w_prod;
   logic [MAN_W-1:0]   w_pm, w_qm;
   logic [W-1:0]       w_res;
   logic [3:0]         w_flg;

   assign w_accept    = in_valid && in_ready;
   assign w_div_start = w_accept && op == 4'b1000;
   assign in_ready    = rst_n && r_state == IDLE;
   assign busy        = r_state != IDLE;
   assign out_valid   = r_valid;
   assign result      = r_res;
   assign flags       = r_flg;

   fpu_mant_div #(.N(MAN_W + 1)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_div_start),
      .num   ({1'b1, a[MAN_W-1:0]}),
      .den   ({1'b1, b[MAN_W-1:0]}),
      .done  (w_div_done),
      .quo   (w_quo)
   );

   assign w_ea  = r_a[W-2 -: EXP_W];
   assign w_eb  = r_b[W-2 -: EXP_W];
   assign w_ca  = classify(&w_ea, ~|w_ea, ~|r_a[MAN_W-1:0]);
   assign w_cb  = classify(&w_eb, ~|w_eb, ~|r_b[MAN_W-1:0]);
   assign w_ma  = w_ca == CLS_NORM ? {1'b1, r_a[MAN_W-1:0]} : '0;
   assign w_mb  = w_cb == CLS_NORM ? {1'b1, r_b[MAN_W-1:0]} : '0;
   assign w_sa  = r_a[W-1];
   assign w_sbe = r_b[W-1] ^ r_op[OP_SUB];
   assign w_sx  = r_a[W-1] ^ r_b[W-1];
   assign w_legal = $onehot(r_op);
   assign w_nan   = w_ca == CLS_NAN || w_cb == CLS_NAN;

   // Add/sub: align the smaller magnitude with 3 guard bits; the sticky bit is
   // subtracted so that effective subtraction still truncates toward zero.
   assign w_swap = {w_eb, w_mb} > {w_ea, w_ma};
   assign w_be   = w_swap ? w_eb : w_ea;
   assign w_se   = w_swap ? w_ea : w_eb;
   assign w_bm   = w_swap ? w_mb : w_ma;
   assign w_sm   = w_swap ? w_ma : w_mb;
   assign w_bs   = w_swap ? w_sbe : w_sa;
   assign w_ss   = w_swap ? w_sa : w_sbe;
   assign w_d    = w_be - w_se;
   assign w_bx   = {w_bm, 3'b0};
   assign w_sxx  = {w_sm, 3'b0};
   assign w_sh   = int'(w_d) >= E ? '0 : w_sxx >> w_d;
   assign w_stk  = int'(w_d) >= E ? |w_sm : (w_sh << w_d) != w_sxx;
   assign w_sum  = (w_bs ^ w_ss) ? {1'b0, w_bx} - {1'b0, w_sh} - {{E{1'b0}}, w_stk}
                                 : {1'b0, w_bx} + {1'b0, w_sh};
   assign w_norm = w_sum[E-1:0] << w_lz;

   always_comb begin
      w_lz = E;
      for (int i = 0; i < E; i++) if (w_sum[i]) w_lz = E - 1 - i;
   end

   assign w_prod = {{(MAN_W+1){1'b0}}, w_ma} * {{(MAN_W+1){1'b0}}, w_mb};
   assign w_pe   = int'(w_ea) + int'(w_eb) - BIAS + int'(w_prod[2*MAN_W+1]);
   assign w_pm   = w_prod[2*MAN_W+1] ? MAN_W'(w_prod >> (MAN_W + 1)) : MAN_W'(w_prod >> MAN_W);
   assign w_qe   = int'(w_ea) - int'(w_eb) + BIAS - 1 + int'(w_quo[MAN_W+1]);
   assign w_qm   = w_quo[MAN_W+1] ? MAN_W'(w_quo >> 1) : MAN_W'(w_quo);

   function automatic logic [W+3:0] pack(input logic s, input int e, input logic [MAN_W-1:0] m);
      return e >= EMAX ? {4'b0100, s, INF_MAG} : e <= 0 ? {4'b1000, s, {(W-1){1'b0}}}
                       : {4'b0000, s, EXP_W'(e), m};
   endfunction

   always_comb begin
      w_flg = 4'b0001;
      w_res = QNAN;
      if (w_legal && w_nan)
         w_flg = '0;
      else if (w_legal && r_op[OP_MUL]) begin
         if (!((w_ca == CLS_ZERO && w_cb == CLS_INF) || (w_ca == CLS_INF && w_cb == CLS_ZERO)))
            {w_flg, w_res} = (w_ca == CLS_INF || w_cb == CLS_INF) ? {4'b0, w_sx, INF_MAG}
                           : (w_ca == CLS_ZERO || w_cb == CLS_ZERO) ? {4'b0, w_sx, {(W-1){1'b0}}}
                           : pack(w_sx, w_pe, w_pm);
      end else if (w_legal && r_op[OP_DIV]) begin
         if (!(w_ca == w_cb && w_ca != CLS_NORM))
            {w_flg, w_res} = w_ca == CLS_INF ? {4'b0, w_sx, INF_MAG}
                           : w_cb == CLS_INF ? {4'b0, w_sx, {(W-1){1'b0}}}
                           : w_cb == CLS_ZERO ? {4'b0010, w_sx, INF_MAG}
                           : w_ca == CLS_ZERO ? {4'b0, w_sx, {(W-1){1'b0}}}
                           : pack(w_sx, w_qe, w_qm);
      end else if (w_legal) begin
         if (!(w_ca == CLS_INF && w_cb == CLS_INF && w_sa != w_sbe))
            {w_flg, w_res} = w_ca == CLS_INF ? {4'b0, w_sa, INF_MAG}
                           : w_cb == CLS_INF ? {4'b0, w_sbe, INF_MAG}
                           : w_sum == '0 ? {(W+4){1'b0}}
                           : w_sum[E] ? pack(w_bs, int'(w_be) + 1, MAN_W'(w_sum >> 4))
                           : pack(w_bs, int'(w_be) - w_lz, MAN_W'(w_norm >> 3));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_res   <= '0;
         r_flg   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               r_a     <= a;
               r_b     <= b;
               r_op    <= op;
               r_state <= w_div_start ? DIV : EXEC;
            end
            EXEC: begin
               r_res   <= w_res;
               r_flg   <= w_flg;
               r_valid <= 1'b1;
               r_state <= HOLD;
            end
            DIV: if (w_div_done) begin
               r_res   <= w_res;
               r_flg   <= w_flg;
               r_valid <= 1'b1;
               r_state <= HOLD;
            end
            HOLD: if (out_ready) begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_exe_stage.sv
// tb_fpu_exe_stage: directed vectors with hand-computed single-precision
// results, latencies, flags and handshake behaviour.
module tb_fpu_exe_stage;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   logic [3:0]  flags;
   int          total = 0, bad = 0, lat = 0;
   logic        seen;

   fpu_exe_stage #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop);
      @(negedge clk);
      a = ia;
      b = ib;
      op = iop;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic retire(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " retire"}, {out_valid, in_ready}, 2'b01);
   endtask

   task automatic expect_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                            input logic [3:0] iop, input logic [31:0] eres,
                            input logic [3:0] eflg, input int elat);
      run_op(ia, ib, iop);
      chk({tag, " valid"}, out_valid, 1'b1);
      chk({tag, " latency"}, lat, elat);
      chk({tag, " result"}, result, eres);
      chk({tag, " flags"}, flags, eflg);
      retire(tag);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset in_ready", in_ready, 1'b0);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset result", result, 32'h0);
      chk("reset flags", flags, 4'h0);
      chk("reset busy", busy, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("post reset in_ready", in_ready, 1'b1);

      expect_op("add",        32'h3F000000, 32'h3E800000, 4'b0001, 32'h3F400000, 4'b0000, 2);
      expect_op("sub",        32'h3F000000, 32'h3E800000, 4'b0010, 32'h3E800000, 4'b0000, 2);
      expect_op("mul",        32'h3F000000, 32'h3E800000, 4'b0100, 32'h3E000000, 4'b0000, 2);
      expect_op("div",        32'h3F000000, 32'h3E800000, 4'b1000, 32'h40000000, 4'b0000, 27);
      expect_op("div by 0",   32'h3F800000, 32'h00000000, 4'b1000, 32'h7F800000, 4'b0010, 27);
      expect_op("0/0",        32'h00000000, 32'h00000000, 4'b1000, 32'h7FC00000, 4'b0001, 27);
      expect_op("inf-inf",    32'h7F800000, 32'h7F800000, 4'b0010, 32'h7FC00000, 4'b0001, 2);
      expect_op("mul ovf",    32'h7F000000, 32'h7F000000, 4'b0100, 32'h7F800000, 4'b0100, 2);
      expect_op("1/3 trunc",  32'h3F800000, 32'h40400000, 4'b1000, 32'h3EAAAAAA, 4'b0000, 27);
      expect_op("sub trunc",  32'h3F800000, 32'h30800000, 4'b0010, 32'h3F7FFFFF, 4'b0000, 2);
      expect_op("add trunc",  32'h3F800000, 32'h30800000, 4'b0001, 32'h3F800000, 4'b0000, 2);
      expect_op("exact zero", 32'h3F800000, 32'hBF800000, 4'b0001, 32'h00000000, 4'b0000, 2);
      expect_op("add ovf",    32'h7F7FFFFF, 32'h7F7FFFFF, 4'b0001, 32'h7F800000, 4'b0100, 2);
      expect_op("mul unf",    32'h00800000, 32'h00800000, 4'b0100, 32'h00000000, 4'b1000, 2);
      expect_op("x/inf",      32'h3F800000, 32'hFF800000, 4'b1000, 32'h80000000, 4'b0000, 27);
      expect_op("nan in",     32'h7FC00001, 32'h3F800000, 4'b0001, 32'h7FC00000, 4'b0000, 2);
      expect_op("denorm mul", 32'h00000001, 32'hBF800000, 4'b0100, 32'h80000000, 4'b0000, 2);
      expect_op("neg mul",    32'hBF800000, 32'h40000000, 4'b0100, 32'hC0000000, 4'b0000, 2);

      run_op(32'h3F800000, 32'h3F800000, 4'b0011);
      chk("illegal valid", out_valid, 1'b1);
      chk("illegal latency", lat, 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold result", result, 32'h7FC00000);
         chk("hold flags", flags, 4'b0001);
         chk("hold handshake", {out_valid, in_ready, busy}, 3'b101);
      end
      retire("illegal");

      @(negedge clk);
      a = 32'h3F800000;
      b = 32'h40400000;
      op = 4'b1000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid div busy", {busy, in_ready, out_valid}, 3'b100);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst abort in_ready", in_ready, 1'b1);
      chk("rst abort busy", busy, 1'b0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("rst abort no output", seen, 1'b0);
      expect_op("add after rst", 32'h3F800000, 32'h3F800000, 4'b0001, 32'h40000000, 4'b0000, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
